// File: rtl/frv_fetch_buffer.sv
// Halfword realignment FIFO between instruction fetch and decode: 32-bit words in,
// one complete 16/32-bit instruction out. Optional same-cycle bypass: FRV_FETCH_BUFFER_BYPASS_EN.
module frv_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        flush_hi,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_error,
  output logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_error,
  output logic [1:0]  o_size,
  input  logic        o_ready
);

  localparam logic [PTRW:0] C_RDY_LIM = (PTRW+1)'(DEPTH - 2);

  logic [15:0]     r_hw [DEPTH];
  logic            r_err[DEPTH];
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW:0]   r_count;
  logic            r_drop_hi;

  logic [PTRW-1:0] w_rd_ptr1;
  logic [PTRW-1:0] w_wr_ptr1;
  logic            w_push;
  logic            w_pop;
  logic            w_byp;
  logic [15:0]     w_h0;
  logic [15:0]     w_h1;
  logic            w_e0;
  logic            w_e1;
  logic            w_have1;
  logic            w_have2;
  logic            w_is32;
  logic [1:0]      w_wr_n;
  logic [15:0]     w_wr_d0;
  logic [15:0]     w_wr_d1;
  logic [1:0]      w_pop_n;

  assign w_rd_ptr1 = r_rd_ptr + PTRW'(1);
  assign w_wr_ptr1 = r_wr_ptr + PTRW'(1);

  // Full means fewer than two free slots; a same-cycle pop earns no credit.
  assign i_ready = (r_count <= C_RDY_LIM);
  assign w_push  = i_valid & i_ready & !flush;

`ifdef FRV_FETCH_BUFFER_BYPASS_EN
  assign w_byp = w_push & (r_count == '0) & !r_drop_hi;
`else
  assign w_byp = 1'b0;
`endif

  // Head view: from storage normally, straight from the incoming word when bypassing.
  always_comb begin
    w_h0    = r_hw[r_rd_ptr];
    w_h1    = r_hw[w_rd_ptr1];
    w_e0    = r_err[r_rd_ptr];
    w_e1    = r_err[w_rd_ptr1];
    w_have1 = (r_count >= (PTRW+1)'(1));
    w_have2 = (r_count >= (PTRW+1)'(2));
    if (w_byp) begin
      w_h0    = i_data[15:0];
      w_h1    = i_data[31:16];
      w_e0    = i_error;
      w_e1    = i_error;
      w_have1 = 1'b1;
      w_have2 = 1'b1;
    end
  end

  // An errored head is always a 16-bit instruction so it never stalls for a partner.
  assign w_is32 = (w_h0[1:0] == 2'b11) & !w_e0;

  always_comb begin
    o_valid = w_have1 & (!w_is32 | w_have2);
    o_data  = 32'h0;
    o_error = 1'b0;
    o_size  = 2'b00;
    if (o_valid) begin
      o_size  = w_is32 ? 2'b10 : 2'b01;
      o_data  = w_is32 ? {w_h1, w_h0} : {16'h0, w_h0};
      o_error = w_e0 | (w_is32 & w_e1);
    end
  end

  assign w_pop = o_valid & o_ready & !flush;

  always_comb begin
    w_wr_n  = 2'd0;
    w_wr_d0 = i_data[15:0];
    w_wr_d1 = i_data[31:16];
    w_pop_n = w_pop ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;
    if (w_push) begin
      if (r_drop_hi) begin
        w_wr_n  = 2'd1;
        w_wr_d0 = i_data[31:16];
      end else if (w_byp && w_pop) begin
        // Bypassed and consumed: keep only the halfword the decoder did not take.
        w_wr_n  = w_is32 ? 2'd0 : 2'd1;
        w_wr_d0 = i_data[31:16];
        w_pop_n = 2'd0;
      end else begin
        w_wr_n = 2'd2;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_resetn && w_push) begin
      if (w_wr_n != 2'd0) begin
        r_hw[r_wr_ptr]  <= w_wr_d0;
        r_err[r_wr_ptr] <= i_error;
      end
      if (w_wr_n == 2'd2) begin
        r_hw[w_wr_ptr1]  <= w_wr_d1;
        r_err[w_wr_ptr1] <= i_error;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_drop_hi <= 1'b0;
    end else if (flush) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_drop_hi <= flush_hi;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTRW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + PTRW'(w_wr_n);
      r_count  <= r_count + (PTRW+1)'(w_wr_n) - (PTRW+1)'(w_pop_n);
      if (w_push) r_drop_hi <= 1'b0;
    end
  end

  a_count_bound: assert property (@(posedge g_clk) disable iff (!g_resetn)
    r_count <= (PTRW+1)'(DEPTH));

endmodule

// File: tb/tb_frv_fetch_buffer.sv
// Directed bench for frv_fetch_buffer (default build, bypass disabled): hand-computed
// expectations for reset, realignment, straddling, flush_hi, fetch errors and full handling.
module tb_frv_fetch_buffer;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic        flush_hi;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_error;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_error;
  logic [1:0]  o_size;
  logic        o_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 g_clk = ~g_clk;

  frv_fetch_buffer #(.DEPTH(4), .PTRW(2)) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .flush   (flush),
    .flush_hi(flush_hi),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_error (i_error),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_error (o_error),
    .o_size  (o_size),
    .o_ready (o_ready)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One clock with the current inputs, then drop the one-shot controls.
  task automatic tick();
    @(posedge g_clk);
    #1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    flush   = 1'b0;
    flush_hi = 1'b0;
    i_error = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    i_valid = 1'b1;
    i_data  = d;
    i_error = e;
    tick();
  endtask

  task automatic pop();
    o_ready = 1'b1;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] sz,
                         input logic [31:0] d, input logic e);
    chk_eq({tag, ".valid"}, 32'(o_valid), 32'(v));
    chk_eq({tag, ".size"},  32'(o_size),  32'(sz));
    chk_eq({tag, ".data"},  o_data,       d);
    chk_eq({tag, ".error"}, 32'(o_error), 32'(e));
  endtask

  initial begin
    g_resetn = 1'b0;
    flush = 1'b0; flush_hi = 1'b0;
    i_valid = 1'b0; i_data = 32'h0; i_error = 1'b0; o_ready = 1'b0;
    tick();
    tick();
    g_resetn = 1'b1;
    chk_out("reset", 1'b0, 2'b00, 32'h0, 1'b0);
    chk_eq("reset.i_ready", 32'(i_ready), 32'd1);

    // Aligned 32-bit instruction
    push(32'h0000_0013, 1'b0);
    chk_out("addi", 1'b1, 2'b10, 32'h0000_0013, 1'b0);
    chk_eq("addi.i_ready", 32'(i_ready), 32'd1);
    pop();
    chk_eq("addi.drained", 32'(o_valid), 32'd0);

    // Two compressed instructions in one word
    push(32'h4501_4505, 1'b0);
    chk_out("cli0", 1'b1, 2'b01, 32'h0000_4505, 1'b0);
    pop();
    chk_out("cli1", 1'b1, 2'b01, 32'h0000_4501, 1'b0);
    pop();
    chk_eq("cli.drained", 32'(o_valid), 32'd0);

    // 32-bit instruction straddling two words
    push(32'h0013_4505, 1'b0);
    chk_out("strad.c", 1'b1, 2'b01, 32'h0000_4505, 1'b0);
    pop();
    chk_out("strad.wait", 1'b0, 2'b00, 32'h0, 1'b0);
    push(32'h4501_0000, 1'b0);
    chk_out("strad.i32", 1'b1, 2'b10, 32'h0000_0013, 1'b0);
    pop();
    chk_out("strad.tail", 1'b1, 2'b01, 32'h0000_4501, 1'b0);
    pop();
    chk_eq("strad.drained", 32'(o_valid), 32'd0);

    // Flush to a halfword-aligned target
    flush = 1'b1; flush_hi = 1'b1;
    tick();
    chk_eq("fhi.after_flush", 32'(o_valid), 32'd0);
    push(32'h0093_ABCD, 1'b0);
    chk_out("fhi.wait", 1'b0, 2'b00, 32'h0, 1'b0);
    chk_eq("fhi.i_ready", 32'(i_ready), 32'd1);
    push(32'h1234_5678, 1'b0);
    chk_out("fhi.i32", 1'b1, 2'b10, 32'h5678_0093, 1'b0);
    pop();
    chk_out("fhi.tail", 1'b1, 2'b01, 32'h0000_1234, 1'b0);
    pop();
    chk_eq("fhi.drained", 32'(o_valid), 32'd0);

    // Fetch error: each errored halfword is delivered alone
    flush = 1'b1;
    tick();
    push(32'hFFFF_FFFF, 1'b1);
    chk_out("err0", 1'b1, 2'b01, 32'h0000_FFFF, 1'b1);
    pop();
    chk_out("err1", 1'b1, 2'b01, 32'h0000_FFFF, 1'b1);
    pop();
    chk_eq("err.drained", 32'(o_valid), 32'd0);

    // Full buffer
    push(32'h0000_0013, 1'b0);
    chk_eq("full.half_ready", 32'(i_ready), 32'd1);
    push(32'h4501_4505, 1'b0);
    chk_eq("full.i_ready", 32'(i_ready), 32'd0);
    push(32'hAAAA_AAAA, 1'b0);
    chk_out("full.head", 1'b1, 2'b10, 32'h0000_0013, 1'b0);
    pop();
    chk_eq("full.ready_after_pop", 32'(i_ready), 32'd1);
    chk_out("full.c0", 1'b1, 2'b01, 32'h0000_4505, 1'b0);
    pop();
    chk_out("full.c1", 1'b1, 2'b01, 32'h0000_4501, 1'b0);
    pop();
    chk_eq("full.ignored_push", 32'(o_valid), 32'd0);

    push(32'h4501_4505, 1'b0);
    push(32'h0000_0013, 1'b0);
    chk_eq("fflush.full", 32'(i_ready), 32'd0);
    flush = 1'b1;
    tick();
    chk_out("fflush", 1'b0, 2'b00, 32'h0, 1'b0);
    chk_eq("fflush.i_ready", 32'(i_ready), 32'd1);
    push(32'h4501_4505, 1'b0);
    chk_out("fflush.refill", 1'b1, 2'b01, 32'h0000_4505, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
